// File: rtl/ccr_unit_pkg.sv
// ccr_defs: ALU opcodes, flag bit indices and jump-condition encodings shared by
// the CCR stage, the ALU and the control unit.
`default_nettype none

package ccr_defs;

  localparam int CCR_FLAG_W = 3;
  localparam int CCR_OP_W   = 4;

  localparam int Z_B = 0;
  localparam int N_B = 1;
  localparam int C_B = 2;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_SETC = 4'b0001;
  localparam logic [3:0] OP_CLRC = 4'b0010;
  localparam logic [3:0] OP_NOP  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_DEC  = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
  localparam logic [3:0] OP_OR   = 4'b1011;
  localparam logic [3:0] OP_SHL  = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_IN   = 4'b1110;
  localparam logic [3:0] OP_OUT  = 4'b1111;

  typedef enum logic [1:0] {
    COND_JMP = 2'b00,
    COND_JZ  = 2'b01,
    COND_JN  = 2'b10,
    COND_JC  = 2'b11
  } br_cond_e;

endpackage

`default_nettype wire

// File: rtl/ccr_unit_if.sv
// ccr_unit_if: EX-stage flag, jump and interrupt signals between the pipeline
// control (master) and the CCR stage (slave).
`default_nettype none

interface ccr_unit_if #(
  parameter int FLAG_W = 3,
  parameter int OP_W   = 4
);
  logic              ex_valid;
  logic [OP_W-1:0]   alu_operation;
  logic [FLAG_W-1:0] alu_flag;
  logic              stall;
  logic              flush;
  logic              br_valid;
  logic [1:0]        br_cond;
  logic              int_save;
  logic              rti_restore;
  logic [FLAG_W-1:0] ccr;
  logic [FLAG_W-1:0] ccr_fwd;
  logic              branch_taken;
  logic              saved_valid;
  logic              restore_err;

  modport master (
    output ex_valid, alu_operation, alu_flag, stall, flush,
           br_valid, br_cond, int_save, rti_restore,
    input  ccr, ccr_fwd, branch_taken, saved_valid, restore_err
  );

  modport slave (
    input  ex_valid, alu_operation, alu_flag, stall, flush,
           br_valid, br_cond, int_save, rti_restore,
    output ccr, ccr_fwd, branch_taken, saved_valid, restore_err
  );
endinterface

`default_nettype wire

// File: rtl/ccr_unit_mask_dec.sv
// ccr_mask_dec: combinational opcode -> flag update mask, bit order {C, N, Z}.
`default_nettype none

module ccr_mask_dec
  import ccr_defs::*;
#(
  parameter int FLAG_W = 3,
  parameter int OP_W   = 4
) (
  input  wire logic [OP_W-1:0]   op_i,
  output logic      [FLAG_W-1:0] mask_o
);

  always_comb begin
    mask_o = '0;
    case (op_i)
      OP_SETC, OP_CLRC: begin
        mask_o[C_B] = 1'b1;
      end
      OP_NOT, OP_DEC, OP_SUB, OP_AND, OP_OR: begin
        mask_o[Z_B] = 1'b1;
        mask_o[N_B] = 1'b1;
      end
      OP_INC, OP_ADD, OP_SHL, OP_SHR: begin
        mask_o[Z_B] = 1'b1;
        mask_o[N_B] = 1'b1;
        mask_o[C_B] = 1'b1;
      end
      default: mask_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register stage downstream of the ALU, with masked flag
// capture, forwarded jump resolution, taken-jump flag clear and a one-deep shadow.
`default_nettype none

module ccr_unit
  import ccr_defs::*;
#(
  parameter int FLAG_W = CCR_FLAG_W,
  parameter int OP_W   = CCR_OP_W
) (
  input wire logic clk,
  input wire logic rst_n,
  ccr_unit_if.slave bus
);

  logic [FLAG_W-1:0] ccr_q;
  logic [FLAG_W-1:0] shadow_q;
  logic              saved_valid_q;
  logic              restore_err_q;

  logic [FLAG_W-1:0] upd_mask;
  logic [FLAG_W-1:0] ccr_fwd;
  logic [FLAG_W-1:0] clr_mask;
  logic [FLAG_W-1:0] ccr_d;
  logic              upd;
  logic              cond_hit;
  logic              taken;

  ccr_mask_dec #(
    .FLAG_W (FLAG_W),
    .OP_W   (OP_W)
  ) u_mask_dec (
    .op_i   (bus.alu_operation),
    .mask_o (upd_mask)
  );

  always_comb begin
    upd      = bus.ex_valid & ~bus.flush & ~bus.stall;
    ccr_fwd  = upd ? ((ccr_q & ~upd_mask) | (bus.alu_flag & upd_mask)) : ccr_q;
    cond_hit = 1'b0;
    clr_mask = '0;
    case (bus.br_cond)
      COND_JMP: cond_hit = 1'b1;
      COND_JZ: begin
        cond_hit      = ccr_fwd[Z_B];
        clr_mask[Z_B] = 1'b1;
      end
      COND_JN: begin
        cond_hit      = ccr_fwd[N_B];
        clr_mask[N_B] = 1'b1;
      end
      COND_JC: begin
        cond_hit      = ccr_fwd[C_B];
        clr_mask[C_B] = 1'b1;
      end
      default: cond_hit = 1'b0;
    endcase
    taken = bus.br_valid & ~bus.stall & cond_hit;
    // The jump is younger than the ALU op, so its clear overrides a same-bit update.
    ccr_d = taken ? (ccr_fwd & ~clr_mask) : ccr_fwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q         <= '0;
      shadow_q      <= '0;
      saved_valid_q <= 1'b0;
      restore_err_q <= 1'b0;
    end else if (bus.stall) begin
      restore_err_q <= 1'b0;
    end else if (bus.rti_restore) begin
      if (saved_valid_q) begin
        ccr_q         <= shadow_q;
        saved_valid_q <= 1'b0;
        restore_err_q <= 1'b0;
      end else begin
        restore_err_q <= 1'b1;
      end
    end else begin
      ccr_q         <= ccr_d;
      restore_err_q <= 1'b0;
      if (bus.int_save) begin
        shadow_q      <= ccr_fwd;
        saved_valid_q <= 1'b1;
      end
    end
  end

  assign bus.ccr          = ccr_q;
  assign bus.ccr_fwd      = ccr_fwd;
  assign bus.branch_taken = taken;
  assign bus.saved_valid  = saved_valid_q;
  assign bus.restore_err  = restore_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ccr_unit.sv
// tb_ccr_unit: directed self-checking bench for ccr_unit.
`default_nettype none

module tb_ccr_unit;
  import ccr_defs::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ccr_unit_if #(.FLAG_W(3), .OP_W(4)) bus ();

  ccr_unit #(.FLAG_W(3), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.ex_valid      = 1'b0;
    bus.alu_operation = OP_NOP;
    bus.alu_flag      = 3'b000;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.br_valid      = 1'b0;
    bus.br_cond       = 2'b00;
    bus.int_save      = 1'b0;
    bus.rti_restore   = 1'b0;
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ccr(input logic [2:0] v);
    idle();
    bus.ex_valid      = 1'b1;
    bus.alu_operation = OP_ADD;
    bus.alu_flag      = v;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.ccr !== 3'b000) begin
      errors++; $display("FAIL reset_ccr: got %b expected 000", bus.ccr);
    end
    checks++;
    if (bus.saved_valid !== 1'b0) begin
      errors++; $display("FAIL reset_saved_valid: got %b expected 0", bus.saved_valid);
    end
    checks++;
    if (bus.restore_err !== 1'b0) begin
      errors++; $display("FAIL reset_restore_err: got %b expected 0", bus.restore_err);
    end
  endtask

  task automatic test_update();
    idle();
    bus.ex_valid      = 1'b1;
    bus.alu_operation = OP_ADD;
    bus.alu_flag      = 3'b101;
    #1;
    checks++;
    if (bus.ccr_fwd !== 3'b101) begin
      errors++; $display("FAIL add_fwd: got %b expected 101", bus.ccr_fwd);
    end
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b101) begin
      errors++; $display("FAIL add_ccr: got %b expected 101", bus.ccr);
    end
    load_ccr(3'b100);
    bus.ex_valid      = 1'b1;
    bus.alu_operation = OP_NOT;
    bus.alu_flag      = 3'b010;
    step();
    checks++;
    if (bus.ccr !== 3'b110) begin
      errors++; $display("FAIL not_keeps_c: got %b expected 110", bus.ccr);
    end
    bus.alu_operation = OP_MOV;
    bus.alu_flag      = 3'b111;
    step();
    checks++;
    if (bus.ccr !== 3'b110) begin
      errors++; $display("FAIL mov_no_update: got %b expected 110", bus.ccr);
    end
    bus.alu_operation = OP_SETC;
    bus.alu_flag      = 3'b001;
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b010) begin
      errors++; $display("FAIL setc_c_only: got %b expected 010", bus.ccr);
    end
  endtask

  task automatic test_branch();
    load_ccr(3'b001);
    bus.br_valid = 1'b1;
    bus.br_cond  = 2'b01;
    #1;
    checks++;
    if (bus.branch_taken !== 1'b1) begin
      errors++; $display("FAIL jz_taken: got %b expected 1", bus.branch_taken);
    end
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b000) begin
      errors++; $display("FAIL jz_clear: got %b expected 000", bus.ccr);
    end
    load_ccr(3'b001);
    bus.br_valid = 1'b1;
    bus.br_cond  = 2'b11;
    #1;
    checks++;
    if (bus.branch_taken !== 1'b0) begin
      errors++; $display("FAIL jc_not_taken: got %b expected 0", bus.branch_taken);
    end
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b001) begin
      errors++; $display("FAIL jc_no_clear: got %b expected 001", bus.ccr);
    end
    load_ccr(3'b111);
    bus.br_valid = 1'b1;
    bus.br_cond  = 2'b00;
    #1;
    checks++;
    if (bus.branch_taken !== 1'b1) begin
      errors++; $display("FAIL jmp_taken: got %b expected 1", bus.branch_taken);
    end
    step();
    checks++;
    if (bus.ccr !== 3'b111) begin
      errors++; $display("FAIL jmp_no_clear: got %b expected 111", bus.ccr);
    end
    bus.br_cond = 2'b10;
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b101) begin
      errors++; $display("FAIL jn_clear: got %b expected 101", bus.ccr);
    end
  endtask

  task automatic test_forward();
    load_ccr(3'b000);
    bus.ex_valid      = 1'b1;
    bus.alu_operation = OP_ADD;
    bus.alu_flag      = 3'b001;
    bus.br_valid      = 1'b1;
    bus.br_cond       = 2'b01;
    #1;
    checks++;
    if (bus.branch_taken !== 1'b1) begin
      errors++; $display("FAIL fwd_jz_taken: got %b expected 1", bus.branch_taken);
    end
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b000) begin
      errors++; $display("FAIL clear_beats_update: got %b expected 000", bus.ccr);
    end
  endtask

  task automatic test_shadow();
    load_ccr(3'b110);
    bus.int_save = 1'b1;
    step();
    idle();
    checks++;
    if (bus.saved_valid !== 1'b1) begin
      errors++; $display("FAIL save_valid: got %b expected 1", bus.saved_valid);
    end
    bus.ex_valid      = 1'b1;
    bus.alu_operation = OP_SUB;
    bus.alu_flag      = 3'b001;
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b101) begin
      errors++; $display("FAIL sub_ccr: got %b expected 101", bus.ccr);
    end
    bus.rti_restore = 1'b1;
    step();
    checks++;
    if (bus.ccr !== 3'b110 || bus.saved_valid !== 1'b0) begin
      errors++; $display("FAIL rti_restore: got ccr=%b sv=%b expected ccr=110 sv=0", bus.ccr, bus.saved_valid);
    end
    step();
    idle();
    checks++;
    if (bus.restore_err !== 1'b1 || bus.ccr !== 3'b110) begin
      errors++; $display("FAIL rti_empty: got err=%b ccr=%b expected err=1 ccr=110", bus.restore_err, bus.ccr);
    end
    step();
    checks++;
    if (bus.restore_err !== 1'b0) begin
      errors++; $display("FAIL restore_err_pulse: got %b expected 0", bus.restore_err);
    end
    bus.int_save = 1'b1;
    step();
    idle();
    load_ccr(3'b011);
    bus.int_save    = 1'b1;
    bus.rti_restore = 1'b1;
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b110 || bus.saved_valid !== 1'b0) begin
      errors++; $display("FAIL restore_beats_save: got ccr=%b sv=%b expected ccr=110 sv=0", bus.ccr, bus.saved_valid);
    end
  endtask

  task automatic test_stall();
    load_ccr(3'b011);
    bus.int_save = 1'b1;
    step();
    idle();
    load_ccr(3'b100);
    bus.stall         = 1'b1;
    bus.ex_valid      = 1'b1;
    bus.alu_operation = OP_ADD;
    bus.alu_flag      = 3'b111;
    bus.br_valid      = 1'b1;
    bus.br_cond       = 2'b01;
    bus.int_save      = 1'b1;
    #1;
    checks++;
    if (bus.branch_taken !== 1'b0) begin
      errors++; $display("FAIL stall_no_branch: got %b expected 0", bus.branch_taken);
    end
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b100 || bus.saved_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got ccr=%b sv=%b expected ccr=100 sv=1", bus.ccr, bus.saved_valid);
    end
    bus.rti_restore = 1'b1;
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b011) begin
      errors++; $display("FAIL stall_shadow_kept: got %b expected 011", bus.ccr);
    end
    bus.flush         = 1'b1;
    bus.ex_valid      = 1'b1;
    bus.alu_operation = OP_ADD;
    bus.alu_flag      = 3'b100;
    #1;
    checks++;
    if (bus.ccr_fwd !== 3'b011) begin
      errors++; $display("FAIL flush_fwd: got %b expected 011", bus.ccr_fwd);
    end
    step();
    idle();
    checks++;
    if (bus.ccr !== 3'b011) begin
      errors++; $display("FAIL flush_ccr: got %b expected 011", bus.ccr);
    end
  endtask

  task automatic test_async_reset();
    load_ccr(3'b111);
    bus.int_save = 1'b1;
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ccr !== 3'b000 || bus.saved_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got ccr=%b sv=%b expected ccr=000 sv=0", bus.ccr, bus.saved_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.rti_restore = 1'b1;
    step();
    idle();
    checks++;
    if (bus.restore_err !== 1'b1 || bus.ccr !== 3'b000) begin
      errors++; $display("FAIL fresh_start: got err=%b ccr=%b expected err=1 ccr=000", bus.restore_err, bus.ccr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_update();
    test_branch();
    test_forward();
    test_shadow();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
